// File: rtl/jzjpcc_mmio_uart_tx.sv
// MMIO UART transmitter: toggle-handshake byte FIFO feeding an 8N1 serialiser.
// Define JZJPCC_UART_TX_PARITY_EN to insert an even-parity bit (8E1 frames).
module jzjpcc_mmio_uart_tx #(
  parameter int unsigned CLOCKS_PER_BIT  = 434,
  parameter int unsigned FIFO_DEPTH_LOG2 = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] txCommand,
  output logic [31:0] txStatus,
  output logic        txd
);

  localparam int unsigned DEPTH  = 1 << FIFO_DEPTH_LOG2;
  localparam int unsigned PTR_W  = FIFO_DEPTH_LOG2;
  localparam int unsigned CNT_W  = FIFO_DEPTH_LOG2 + 1;
  localparam int unsigned BAUD_W = $clog2(CLOCKS_PER_BIT);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd4;
`ifdef JZJPCC_UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif

  logic             r_prev_toggle;
  logic             r_ack_toggle;
  logic             r_overflow;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [7:0]       r_mem [DEPTH];

  logic [2:0]        r_state;
  logic [BAUD_W-1:0] r_baud;
  logic [2:0]        r_bit_idx;
  logic [7:0]        r_shift;
  logic              r_txd;
`ifdef JZJPCC_UART_TX_PARITY_EN
  logic              r_parity;
`endif

  logic [2:0]        w_state_nxt;
  logic [BAUD_W-1:0] w_baud_nxt;
  logic [2:0]        w_bit_nxt;
  logic [7:0]        w_shift_nxt;
  logic              w_txd_nxt;
  logic              w_pop;

  logic w_push_req;
  logic w_full;
  logic w_push;
  logic w_busy;
  logic w_baud_done;
  logic w_unused_cmd;

  assign w_push_req   = txCommand[8] ^ r_prev_toggle;
  assign w_full       = (r_count == CNT_W'(DEPTH));
  assign w_push       = w_push_req & ~w_full;
  assign w_busy       = (r_state != S_IDLE) | (r_count != '0);
  assign w_baud_done  = (r_baud == BAUD_W'(CLOCKS_PER_BIT - 1));
  assign w_unused_cmd = &{1'b0, txCommand[31:10]};

  // Handshake, overflow and FIFO bookkeeping; full is judged before any same-cycle pop
  always_ff @(posedge clock) begin
    if (reset) begin
      r_prev_toggle <= txCommand[8];
      r_ack_toggle  <= txCommand[8];
      r_overflow    <= 1'b0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
    end else begin
      r_prev_toggle <= txCommand[8];
      if (w_push) begin
        r_wr_ptr     <= r_wr_ptr + PTR_W'(1);
        r_ack_toggle <= txCommand[8];
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_push_req && w_full) begin
        r_overflow <= 1'b1;
      end else if (txCommand[9]) begin
        r_overflow <= 1'b0;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && w_push) begin
      r_mem[r_wr_ptr] <= txCommand[7:0];
    end
  end

  // Frame sequencer state register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_txd     <= 1'b1;
`ifdef JZJPCC_UART_TX_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_baud    <= w_baud_nxt;
      r_bit_idx <= w_bit_nxt;
      r_shift   <= w_shift_nxt;
      r_txd     <= w_txd_nxt;
`ifdef JZJPCC_UART_TX_PARITY_EN
      if (w_pop) begin
        r_parity <= ^r_mem[r_rd_ptr];
      end
`endif
    end
  end

  // Next-state and next-txd; the baud counter restarts at every state entry
  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud + BAUD_W'(1);
    w_bit_nxt   = r_bit_idx;
    w_shift_nxt = r_shift;
    w_txd_nxt   = r_txd;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_txd_nxt  = 1'b1;
        w_baud_nxt = '0;
        if (r_count != '0) begin
          w_pop       = 1'b1;
          w_shift_nxt = r_mem[r_rd_ptr];
          w_state_nxt = S_START;
          w_txd_nxt   = 1'b0;
        end
      end
      S_START: begin
        if (w_baud_done) begin
          w_state_nxt = S_DATA;
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
          w_txd_nxt   = r_shift[0];
        end
      end
      S_DATA: begin
        if (w_baud_done) begin
          w_baud_nxt  = '0;
          w_shift_nxt = {1'b0, r_shift[7:1]};
          w_bit_nxt   = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) begin
`ifdef JZJPCC_UART_TX_PARITY_EN
            w_state_nxt = S_PARITY;
            w_txd_nxt   = r_parity;
`else
            w_state_nxt = S_STOP;
            w_txd_nxt   = 1'b1;
`endif
          end else begin
            w_txd_nxt = r_shift[1];
          end
        end
      end
`ifdef JZJPCC_UART_TX_PARITY_EN
      S_PARITY: begin
        if (w_baud_done) begin
          w_state_nxt = S_STOP;
          w_baud_nxt  = '0;
          w_txd_nxt   = 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (w_baud_done) begin
          w_state_nxt = S_IDLE;
          w_baud_nxt  = '0;
          w_txd_nxt   = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_baud_nxt  = '0;
        w_txd_nxt   = 1'b1;
      end
    endcase
  end

  assign txd      = r_txd;
  assign txStatus = {16'h0000, 4'(r_count), r_overflow, w_full, w_busy, r_ack_toggle, 8'h00};

endmodule

// File: tb/tb_jzjpcc_mmio_uart_tx.sv
// Bench for jzjpcc_mmio_uart_tx: directed stimulus, expected bytes queued to a
// scoreboard drained by a txd frame monitor. Honours JZJPCC_UART_TX_PARITY_EN.
module tb_jzjpcc_mmio_uart_tx;

  localparam int CPB = 4;
`ifdef JZJPCC_UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME_GAP = NB * CPB + 1;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] cmd   = 32'h0;
  logic [31:0] txStatus;
  logic        txd;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc   = 0;
  logic [7:0]  exp_q [$];
  int          starts [$];
  logic        tog = 1'b0;

  jzjpcc_mmio_uart_tx #(.CLOCKS_PER_BIT(CPB), .FIFO_DEPTH_LOG2(2)) dut (
    .clock(clock), .reset(reset), .txCommand(cmd), .txStatus(txStatus), .txd(txd)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic queue_it);
    tog = ~tog;
    cmd[8] = tog;
    cmd[7:0] = d;
    if (queue_it) exp_q.push_back(d);
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (txStatus[9] && n < max) begin
      tick();
      n++;
    end
    chk("drain_busy", 32'(txStatus[9]), 32'd0);
    chk("drain_sb_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // Frame monitor: decodes each frame on txd and checks it against the scoreboard
  initial begin
    forever begin
      @(negedge clock);
      if (!reset && txd === 1'b0) begin
        logic [10:0] bits;
        logic        bad;
        logic        abort;
        logic [7:0]  eb;
        logic        par_a;
        logic        par_e;
        int          st;
        st = cyc;
        bits = '0;
        bad = 1'b0;
        abort = 1'b0;
        for (int b = 0; b < NB && !abort; b++) begin
          for (int c = 0; c < CPB && !abort; c++) begin
            if (!(b == 0 && c == 0)) @(negedge clock);
            if (reset) abort = 1'b1;
            else if (c == 0) bits[b] = txd;
            else if (txd !== bits[b]) bad = 1'b1;
          end
        end
        if (!abort) begin
          starts.push_back(st);
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_frame: got byte %h expected no frame", bits[8:1]);
          end else begin
            eb = exp_q.pop_front();
`ifdef JZJPCC_UART_TX_PARITY_EN
            par_a = bits[9];
            par_e = ^eb;
`else
            par_a = 1'b0;
            par_e = 1'b0;
`endif
            chk("frame", {20'h0, bad, bits[0], bits[NB-1], par_a, bits[8:1]},
                         {20'h0, 1'b0, 1'b0, 1'b1, par_e, eb});
          end
        end
      end
    end
  end

  initial begin
    // reset state
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("reset_status", txStatus, 32'h0000_0000);
    chk("reset_txd", 32'(txd), 32'd1);

    // single frame 0x55 and its latency
    send(8'h55, 1'b1);
    tick();
    chk("t1_ack_count", txStatus, 32'h0000_1300);
    chk("t1_txd_idle", 32'(txd), 32'd1);
    tick();
    chk("t1_start_txd", 32'(txd), 32'd0);
    chk("t1_started", txStatus, 32'h0000_0300);
    repeat (39) tick();
    chk("t1_busy_stop", {30'h0, txStatus[9], txd}, 32'd3);
    repeat (NB * CPB - 40) tick();
    tick();
    chk("t1_idle", txStatus, 32'h0000_0100);

    // four back-to-back bytes
    starts.delete();
    for (int i = 0; i < 4; i++) begin
      send(8'(i + 1), 1'b1);
      tick();
      chk("t2_ack", 32'(txStatus[8]), 32'(tog));
    end
    chk("t2_status", txStatus, 32'h0000_3300);
    cmd[7:0] = 8'h00;
    wait_idle(400);
    chk("t2_nframes", 32'(starts.size()), 32'd4);
    if (starts.size() == 4) begin
      for (int i = 1; i < 4; i++) chk("t2_gap", 32'(starts[i] - starts[i-1]), 32'(FRAME_GAP));
    end

    // overflow with the serialiser busy mid-frame
    send(8'hC3, 1'b1);
    tick();
    tick();
    for (int i = 0; i < 6; i++) begin
      send(8'(8'h10 + i), i < 4);
      tick();
      if (i == 3) chk("t3_full", txStatus, 32'h0000_4600);
    end
    chk("t3_overflow", txStatus, 32'h0000_4E00);
    cmd[9] = 1'b1;
    tick();
    cmd[9] = 1'b0;
    chk("t3_clear", txStatus, 32'h0000_4600);
    wait_idle(600);

    // reset held with toggle already high
    tog = 1'b1;
    cmd[8] = 1'b1;
    cmd[7:0] = 8'h77;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    repeat (3) tick();
    chk("t4_status", txStatus, 32'h0000_0100);
    chk("t4_txd", 32'(txd), 32'd1);

    // reset during data bit 3 of 0xA5 with another byte queued
    send(8'hA5, 1'b1);
    tick();
    send(8'h5A, 1'b1);
    tick();
    repeat (16) tick();
    chk("t5_bit3", {31'h0, txd}, 32'd0);
    reset = 1'b1;
    tick();
    chk("t5_txd", 32'(txd), 32'd1);
    chk("t5_status", txStatus, 32'h0000_0100);
    exp_q.delete();
    reset = 1'b0;
    repeat (60) tick();
    chk("t5_quiet", {txStatus[31:1], txd}, 32'h0000_0101);

    // parity-sensitive bytes
    send(8'h07, 1'b1);
    tick();
    send(8'h03, 1'b1);
    tick();
    wait_idle(300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
